// File: rtl/integracao_pkg.sv
// integracao_pkg
// Shared definitions for the registered 7-segment display path:
//   - seg_t: 7-bit segment word, bit order {g,f,e,d,c,b,a}, a = bit 0
//   - OP_*: operation codes found in entrada[5:4]
//   - SEG_0 .. SEG_F: active-high segment patterns for hex digits 0..F
//   - field helpers that split the 6-bit operation word
package integracao_pkg;

  typedef logic [6:0] seg_t;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_MUL     = 2'b01;
  localparam logic [1:0] OP_ABSDIFF = 2'b10;
  localparam logic [1:0] OP_CAT     = 2'b11;

  // Active-high patterns, {g,f,e,d,c,b,a}
  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_A = 7'h77;
  localparam seg_t SEG_B = 7'h7C;
  localparam seg_t SEG_C = 7'h39;
  localparam seg_t SEG_D = 7'h5E;
  localparam seg_t SEG_E = 7'h79;
  localparam seg_t SEG_F = 7'h71;

  // Field extraction from the operation word {op[1:0], a[1:0], b[1:0]}
  function automatic logic [1:0] word_op(input logic [5:0] w);
    return w[5:4];
  endfunction

  function automatic logic [1:0] word_a(input logic [5:0] w);
    return w[3:2];
  endfunction

  function automatic logic [1:0] word_b(input logic [5:0] w);
    return w[1:0];
  endfunction

endpackage

// File: rtl/integracao_hex_to_7seg.sv
// hex_to_7seg
// Combinational hex digit to 7-segment decoder, active-high outputs.
// Ports:
//   digito    in  4  value 0..15
//   segmentos out 7  {g,f,e,d,c,b,a}, a = bit 0, 1 = segment lit
module hex_to_7seg
  import integracao_pkg::*;
(
  input  logic [3:0] digito,
  output seg_t       segmentos
);

  always_comb begin
    segmentos = SEG_0;
    case (digito)
      4'h0: segmentos = SEG_0;
      4'h1: segmentos = SEG_1;
      4'h2: segmentos = SEG_2;
      4'h3: segmentos = SEG_3;
      4'h4: segmentos = SEG_4;
      4'h5: segmentos = SEG_5;
      4'h6: segmentos = SEG_6;
      4'h7: segmentos = SEG_7;
      4'h8: segmentos = SEG_8;
      4'h9: segmentos = SEG_9;
      4'hA: segmentos = SEG_A;
      4'hB: segmentos = SEG_B;
      4'hC: segmentos = SEG_C;
      4'hD: segmentos = SEG_D;
      4'hE: segmentos = SEG_E;
      4'hF: segmentos = SEG_F;
      default: segmentos = SEG_0;
    endcase
  end

endmodule

// File: rtl/integracao.sv
// integracao
// Top of the display path: splits a 6-bit operation word into op and two
// 2-bit unsigned operands, computes a 4-bit result, decodes it to a
// 7-segment pattern and registers the pattern.
//
// Ports:
//   clk       in  1  system clock, rising edge
//   rst       in  1  asynchronous active-high reset; output forced to "all off"
//   entrada   in  6  {op[1:0], a[1:0], b[1:0]}
//   segmentos out 7  registered segment drive {g,f,e,d,c,b,a}
//
// Interface timing: no valid/ready handshake. A new word is accepted on every
// rising clk edge and its pattern appears on segmentos after that edge
// (one cycle latency). Changes of entrada between edges are never visible.
//
// Configuration macro: SEG_ACTIVE_LOW_EN
//   defined   -> patterns complemented for common-anode displays, reset 7'h7F
//   undefined -> active-high patterns, reset 7'h00
module integracao
  import integracao_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] entrada,
  output seg_t       segmentos
);

  logic [1:0] op;
  logic [1:0] opa;
  logic [1:0] opb;
  logic [3:0] resultado;
  seg_t       seg_hex;
  seg_t       seg_next;

  assign op  = word_op(entrada);
  assign opa = word_a(entrada);
  assign opb = word_b(entrada);

  // Every result fits in 4 bits (max 15 for concatenation), so the
  // operands are zero-extended to 4 bits and no wrap handling is needed.
  always_comb begin
    resultado = 4'h0;
    case (op)
      OP_ADD:     resultado = {2'b00, opa} + {2'b00, opb};
      OP_MUL:     resultado = {2'b00, opa} * {2'b00, opb};
      OP_ABSDIFF: resultado = (opa >= opb) ? {2'b00, opa - opb}
                                           : {2'b00, opb - opa};
      OP_CAT:     resultado = {opa, opb};
      default:    resultado = 4'h0;
    endcase
  end

  hex_to_7seg u_hex_to_7seg (
    .digito    (resultado),
    .segmentos (seg_hex)
  );

  // Polarity is fixed ahead of the register so latency is identical in both
  // builds and the "all off" reset value follows the display type.
`ifdef SEG_ACTIVE_LOW_EN
  localparam seg_t SEG_OFF = 7'h7F;
  assign seg_next = ~seg_hex;
`else
  localparam seg_t SEG_OFF = 7'h00;
  assign seg_next = seg_hex;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      segmentos <= SEG_OFF;
    end else begin
      segmentos <= seg_next;
    end
  end

endmodule

// File: tb/tb_integracao.sv
// tb_integracao
// Randomized and directed stimulus for integracao, with a behavioural
// reference model, an expected-value queue filled by the driver and a monitor
// that pops and compares one cycle later.
module tb_integracao;

  logic       clk;
  logic       rst;
  logic [5:0] entrada;
  logic [6:0] segmentos;

  int vectors;
  int miscompares;

  logic [6:0] exp_q[$];

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [6:0] OFF_VAL = 7'h7F;
`else
  localparam logic [6:0] OFF_VAL = 7'h00;
`endif

  integracao dut (
    .clk       (clk),
    .rst       (rst),
    .entrada   (entrada),
    .segmentos (segmentos)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: arithmetic straight from the operation table,
  // segment table straight from the hex glyph list.
  function automatic logic [6:0] model(input int w);
    int op, a, b, r;
    logic [6:0] glyph [16];
    logic [6:0] s;
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    op = (w / 16) % 4;
    a  = (w / 4) % 4;
    b  = w % 4;
    case (op)
      0: r = a + b;
      1: r = a * b;
      2: r = (a > b) ? a - b : b - a;
      default: r = a * 4 + b;
    endcase
    s = glyph[r];
`ifdef SEG_ACTIVE_LOW_EN
    s = ~s;
`endif
    return s;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if ($isunknown(act) || act !== exp) begin
      miscompares++;
      $display("FAIL %s: segmentos=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: one word per cycle, driven on the falling edge
  task automatic apply(input int w);
    @(negedge clk);
    entrada = w[5:0];
    exp_q.push_back(model(w));
  endtask

  // Async reset pulse between edges; checks the immediate clear and that
  // the output stays off across edges while entrada keeps changing.
  task automatic reset_pulse(input string name);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check({name, "_immediate"}, segmentos, OFF_VAL);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      entrada = 6'($urandom_range(0, 63));
      #1;
      check({name, "_held"}, segmentos, OFF_VAL);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      logic [6:0] e;
      e = exp_q.pop_front();
      check("seg", segmentos, e);
    end
  end

  initial begin
    int directed [6];
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    entrada     = 6'd0;
    directed    = '{0, 31, 39, 14, 63, 58};

    // Reset state while clock and input toggle
    #1;
    check("reset_initial", segmentos, OFF_VAL);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      entrada = 6'($urandom_range(0, 63));
      @(posedge clk);
      #1;
      check("reset_initial_held", segmentos, OFF_VAL);
    end
    // Release together with the first word; next edge must show its decode
    @(negedge clk);
    rst = 1'b0;
    entrada = 6'd14;
    exp_q.push_back(model(14));

    // Directed words from the operation table
    foreach (directed[i]) apply(directed[i]);

    // Full sweep with an async reset in the middle
    for (int i = 0; i < 64; i++) begin
      apply(i);
      if (i == 30) begin
        @(posedge clk);
        #2;
        reset_pulse("reset_midsweep");
      end
    end

    // Random words
    for (int i = 0; i < 200; i++) begin
      apply($urandom_range(0, 63));
    end

    // Drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d pending expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/integracao.md
# integracao

Registered 6-bit-code-to-7-segment block: decodes a 6-bit selector word into a 4-bit result and drives one 7-segment digit. It is the top-level integration block of the combinational display path. The input word is split into an operation code and two 2-bit operands; a small arithmetic unit computes the result and a hex decoder produces the segment pattern. The output is registered so the block sits cleanly in a clocked system.

## Interface
- No parameters.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `entrada`  input  6  operation word: `[5:4]` op, `[3:2]` operand A, `[1:0]` operand B (all unsigned).
- `segmentos`  output  7  segment drive `{g,f,e,d,c,b,a}`; `a` = bit 0; active-high by default.

## Operation
- Op `00`: R = A + B, range 0..6.
- Op `01`: R = A × B, range 0..9.
- Op `10`: R = |A − B|, range 0..3.
- Op `11`: R = {A,B}, range 0..15, displayed as hex.
- R is 4 bits wide; no operation can overflow it, so no saturation or wrap logic exists.
- Hex decode of R to `{g..a}`:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- All 64 input codes are legal. There are no don't-care codes and no error state.

## Timing
- `segmentos` is a register loaded on every rising `clk` edge with decode(`entrada`) sampled at that edge.
- Latency is one cycle. No handshake; the block accepts new input every cycle.
- While `rst` is high, `segmentos` = 7'h00 (all segments off). Reset takes effect immediately, without waiting for a clock edge, and also applies mid-operation.
- The first rising edge after `rst` deasserts loads decode(`entrada`).
- An input change between edges is not visible until the next edge. There are no glitches on `segmentos`.

## Configuration
- `SEG_ACTIVE_LOW_EN`:
  - When defined, every segment output is inverted for common-anode displays. Decoded patterns are bitwise complemented, and the reset value becomes 7'h7F (all off).
  - When undefined, output is active-high and the reset value is 7'h00.
- Inversion is applied before the output register, so latency is unchanged.

## Structure
- Shared package `integracao_pkg` holds:
  - op-code constants `OP_ADD`, `OP_MUL`, `OP_ABSDIFF`, `OP_CAT`;
  - the 16-entry segment pattern constants;
  - the 7-bit segment-word typedef.
- One sub-module, `hex_to_7seg`: combinational, 4-bit in, 7-bit out, active-high.
- The top level holds the op decode, the arithmetic, the optional inversion and the output register.

## Test plan
- Assert `rst`, toggle `clk` and `entrada` → `segmentos` stays 7'h00 (7'h7F with `SEG_ACTIVE_LOW_EN`); release → next edge shows the decode.
- Apply `entrada` = 0 → after one edge `segmentos` = 7'h3F (digit 0).
- Apply `entrada` = 31 (mul 3×3) → 7'h6F (9); `entrada` = 39 (|1−3|) → 7'h5B (2); `entrada` = 14 (add 3+2) → 7'h6D (5).
- Apply `entrada` = 63 (cat 3,3) → 7'h71 (F); `entrada` = 58 (cat 2,2) → 7'h77 (A).
- Sweep `entrada` 0..63, one value per cycle:
  - every output matches the reference model, delayed exactly one cycle;
  - no X/Z appears on `segmentos`.
- Assert `rst` asynchronously between clock edges during the sweep → output clears immediately; operation resumes on the first edge after release.
